// File: rtl/hdlc_rx_framer.sv
// HDLC receive framer: flag/abort detection, zero-bit removal and LSB-first byte assembly.
// Line bits are judged as they leave an 8-bit window, so flag and abort bits are never taken as data.
module hdlc_rx_framer (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Rx,
    input  logic       Rx_Enable,
    output logic       Rx_FlagDetect,
    output logic       Rx_AbortDetect,
    output logic       Rx_ValidFrame,
    output logic       Rx_AbortSignal,
    output logic [7:0] Rx_Data,
    output logic       Rx_NewByte,
    output logic       Rx_EoF,
    output logic       Rx_FrameError
);

    typedef enum logic [1:0] {IDLE, OPEN_EMPTY, OPEN_DATA} state_t;

    state_t      state, stateNext;
    logic        rx_p0;
    logic [7:0]  window_p0;
    logic [2:0]  skipCnt, skipCntNext;
    logic [2:0]  onesCnt, onesCntNext;
    logic [2:0]  bitCnt, bitCntNext;
    logic [7:0]  shiftReg, shiftRegNext;
    logic        isFlag, isAbort, dataBit;
    logic        byteDone, closeFrame, closeErr, closeAbort;
    logic        vld_p1, close_p1, closeErr_p1, closeAbort_p1;
    logic [7:0]  byte_p1;

    assign isFlag  = (window_p0 == 8'h7E);
    assign isAbort = (window_p0 == 8'h7F);
    assign dataBit = window_p0[7];

    always_comb begin
        stateNext    = state;
        skipCntNext  = skipCnt;
        onesCntNext  = onesCnt;
        bitCntNext   = bitCnt;
        shiftRegNext = shiftReg;
        byteDone     = 1'b0;
        closeFrame   = 1'b0;
        closeErr     = 1'b0;
        closeAbort   = 1'b0;
        case (state)
            IDLE: begin
                if (isFlag && Rx_Enable) begin
                    stateNext   = OPEN_EMPTY;
                    skipCntNext = 3'd7;
                    onesCntNext = 3'd0;
                    bitCntNext  = 3'd0;
                end
            end
            default: begin
                if (isFlag) begin
                    if (state == OPEN_DATA) begin
                        stateNext  = IDLE;
                        closeFrame = 1'b1;
                        closeErr   = (bitCnt != 3'd0);
                    end else begin
                        // The remaining seven flag bits still have to drain out of the window.
                        skipCntNext = 3'd7;
                    end
                    onesCntNext = 3'd0;
                    bitCntNext  = 3'd0;
                end else if (isAbort) begin
                    stateNext   = IDLE;
                    closeFrame  = 1'b1;
                    closeErr    = 1'b1;
                    closeAbort  = 1'b1;
                    onesCntNext = 3'd0;
                    bitCntNext  = 3'd0;
                end else if (skipCnt != 3'd0) begin
                    skipCntNext = skipCnt - 3'd1;
                end else if (onesCnt == 3'd5 && !dataBit) begin
                    onesCntNext = 3'd0;
                end else begin
                    stateNext    = OPEN_DATA;
                    shiftRegNext = {dataBit, shiftReg[7:1]};
                    bitCntNext   = bitCnt + 3'd1;
                    byteDone     = (bitCnt == 3'd7);
                    if (!dataBit)
                        onesCntNext = 3'd0;
                    else if (onesCnt != 3'd7)
                        onesCntNext = onesCnt + 3'd1;
                end
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state          <= IDLE;
            rx_p0          <= 1'b1;
            window_p0      <= 8'hFF;
            skipCnt        <= 3'd0;
            onesCnt        <= 3'd0;
            bitCnt         <= 3'd0;
            Rx_FlagDetect  <= 1'b0;
            Rx_AbortDetect <= 1'b0;
            vld_p1         <= 1'b0;
            close_p1       <= 1'b0;
            closeErr_p1    <= 1'b0;
            closeAbort_p1  <= 1'b0;
            Rx_ValidFrame  <= 1'b0;
            Rx_NewByte     <= 1'b0;
            Rx_Data        <= 8'h00;
            Rx_EoF         <= 1'b0;
            Rx_FrameError  <= 1'b0;
            Rx_AbortSignal <= 1'b0;
        end else begin
            // p0: line sample and detection window
            rx_p0          <= Rx;
            window_p0      <= {window_p0[6:0], rx_p0};
            state          <= stateNext;
            skipCnt        <= skipCntNext;
            onesCnt        <= onesCntNext;
            bitCnt         <= bitCntNext;
            // p1: registered detection and frame events
            Rx_FlagDetect  <= isFlag;
            Rx_AbortDetect <= isAbort;
            vld_p1         <= byteDone;
            close_p1       <= closeFrame;
            closeErr_p1    <= closeErr;
            closeAbort_p1  <= closeAbort;
            // p2: frame status and byte outputs
            Rx_ValidFrame  <= (state != IDLE);
            Rx_NewByte     <= vld_p1;
            if (vld_p1)
                Rx_Data <= byte_p1;
            Rx_EoF         <= close_p1;
            Rx_FrameError  <= close_p1 & closeErr_p1;
            Rx_AbortSignal <= close_p1 & closeAbort_p1;
        end
    end

    always_ff @(posedge Clk) begin
        shiftReg <= shiftRegNext;
        byte_p1  <= shiftRegNext;
    end

endmodule

// File: tb/tb_hdlc_rx_framer.sv
// Directed bench for hdlc_rx_framer: line-level bit sender with a scoreboard of timed frame events.
module tb_hdlc_rx_framer;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       Rx = 1'b1;
    logic       Rx_Enable = 1'b1;
    logic       Rx_FlagDetect, Rx_AbortDetect, Rx_ValidFrame, Rx_AbortSignal;
    logic [7:0] Rx_Data;
    logic       Rx_NewByte, Rx_EoF, Rx_FrameError;

    hdlc_rx_framer dut (
        .Clk(Clk), .Rst(Rst), .Rx(Rx), .Rx_Enable(Rx_Enable),
        .Rx_FlagDetect(Rx_FlagDetect), .Rx_AbortDetect(Rx_AbortDetect),
        .Rx_ValidFrame(Rx_ValidFrame), .Rx_AbortSignal(Rx_AbortSignal),
        .Rx_Data(Rx_Data), .Rx_NewByte(Rx_NewByte), .Rx_EoF(Rx_EoF),
        .Rx_FrameError(Rx_FrameError)
    );

    always #5 Clk = ~Clk;

    typedef struct { int cyc; logic [7:0] data; } byte_t;
    typedef struct { int cyc; logic err; logic abt; } eof_t;

    int    cyc = 0;
    int    checks = 0;
    int    failures = 0;
    int    flagQ[$];
    int    abortQ[$];
    int    riseQ[$];
    byte_t byteQ[$];
    eof_t  eofQ[$];
    logic  prevVF = 1'b0;

    logic [7:0] hist = 8'hFF;
    logic       mOpen = 1'b0;
    int         mBits = 0;
    int         mOnes = 0;
    logic [7:0] mAcc = 8'h00;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [14:0] outs();
        return {Rx_FlagDetect, Rx_AbortDetect, Rx_ValidFrame, Rx_AbortSignal,
                Rx_Data, Rx_NewByte, Rx_EoF, Rx_FrameError};
    endfunction

    always @(negedge Clk) begin
        if (Rst) begin
            prevVF <= 1'b0;
        end else begin
            if (Rx_FlagDetect) begin
                chk("flag_pending", 32'(flagQ.size() != 0), 1);
                if (flagQ.size() != 0) chk("flag_cycle", cyc, flagQ.pop_front());
            end
            if (Rx_AbortDetect) begin
                chk("abort_pending", 32'(abortQ.size() != 0), 1);
                if (abortQ.size() != 0) chk("abort_cycle", cyc, abortQ.pop_front());
            end
            if (Rx_NewByte) begin
                chk("byte_pending", 32'(byteQ.size() != 0), 1);
                if (byteQ.size() != 0) begin
                    byte_t e;
                    e = byteQ.pop_front();
                    chk("byte_cycle", cyc, e.cyc);
                    chk("byte_data", Rx_Data, e.data);
                end
            end
            if (Rx_EoF) begin
                chk("eof_pending", 32'(eofQ.size() != 0), 1);
                if (eofQ.size() != 0) begin
                    eof_t e;
                    e = eofQ.pop_front();
                    chk("eof_cycle", cyc, e.cyc);
                    chk("eof_frame_error", Rx_FrameError, e.err);
                    chk("eof_abort_signal", Rx_AbortSignal, e.abt);
                    chk("eof_valid_fall", {prevVF, Rx_ValidFrame}, 2'b10);
                end
            end
            if (Rx_AbortSignal) chk("abortsig_with_eof", Rx_EoF, 1);
            if (Rx_FrameError)  chk("frameerr_with_eof", Rx_EoF, 1);
            if (Rx_ValidFrame && !prevVF) begin
                chk("vf_rise_pending", 32'(riseQ.size() != 0), 1);
                if (riseQ.size() != 0) chk("vf_rise_cycle", cyc, riseQ.pop_front());
            end
            if (!Rx_ValidFrame && prevVF) chk("vf_fall_with_eof", Rx_EoF, 1);
            prevVF <= Rx_ValidFrame;
        end
    end

    task automatic sendBit(input logic b, output int s);
        @(negedge Clk);
        Rx = b;
        s = cyc + 1;
        hist = {hist[6:0], b};
        if (hist == 8'h7E) flagQ.push_back(s + 2);
        if (hist == 8'h7F) abortQ.push_back(s + 2);
    endtask

    task automatic idle(input int n);
        int s;
        for (int i = 0; i < n; i++) sendBit(1'b1, s);
    endtask

    task automatic sendFlag();
        logic [7:0] pat;
        int s;
        pat = 8'h7E;
        for (int i = 7; i >= 0; i--) sendBit(pat[i], s);
        if (mOpen && mBits > 0) begin
            eofQ.push_back('{s + 3, logic'((mBits % 8) != 0), 1'b0});
            mOpen = 1'b0;
        end else if (mOpen || Rx_Enable) begin
            if (!mOpen) riseQ.push_back(s + 3);
            mOpen = 1'b1;
        end
        mBits = 0;
        mOnes = 0;
    endtask

    task automatic sendAbort();
        logic [7:0] pat;
        int s;
        pat = 8'h7F;
        for (int i = 7; i >= 0; i--) sendBit(pat[i], s);
        if (mOpen) eofQ.push_back('{s + 3, 1'b1, 1'b1});
        mOpen = 1'b0;
        mBits = 0;
        mOnes = 0;
    endtask

    task automatic sendData(input logic [15:0] v, input int n);
        int s;
        int t;
        for (int i = 0; i < n; i++) begin
            sendBit(v[i], s);
            mBits++;
            mAcc = {v[i], mAcc[7:1]};
            if (mBits % 8 == 0) byteQ.push_back('{s + 10, mAcc});
            mOnes = v[i] ? mOnes + 1 : 0;
            if (mOnes == 5) begin
                sendBit(1'b0, t);
                mOnes = 0;
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge Clk);
        chk("reset_outputs", outs(), 0);
        Rst = 1'b0;

        idle(30);
        chk("idle_outputs", outs(), 0);

        sendFlag(); sendData(16'h00A5, 8); sendFlag(); idle(12);
        chk("data_held_a5", Rx_Data, 8'hA5);

        sendFlag(); sendData(16'h00FF, 8); sendFlag(); idle(12);
        chk("data_held_ff", Rx_Data, 8'hFF);

        sendFlag(); sendData(16'h0012, 8); sendData(16'h0005, 3); sendAbort(); idle(12);
        chk("data_after_abort", Rx_Data, 8'h12);
        chk("vf_after_abort", Rx_ValidFrame, 0);

        sendFlag(); sendFlag(); sendData(16'h04C9, 11); sendFlag(); idle(12);
        chk("data_held_c9", Rx_Data, 8'hC9);

        Rx_Enable = 1'b0;
        sendFlag(); idle(3);
        Rx_Enable = 1'b1;
        idle(12);
        chk("vf_disabled", Rx_ValidFrame, 0);

        sendFlag(); sendData(16'h000B, 5);
        chk("vf_before_reset", Rx_ValidFrame, 1);
        #2 Rst = 1'b1;
        Rx = 1'b1;
        #1 chk("async_reset_outputs", outs(), 0);
        chk("reset_eof_queue", eofQ.size(), 0);
        chk("reset_byte_queue", byteQ.size(), 0);
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
        hist = 8'hFF; mOpen = 1'b0; mBits = 0; mOnes = 0;
        flagQ.delete(); abortQ.delete(); riseQ.delete();

        sendFlag(); sendData(16'h003C, 8); sendFlag(); idle(20);
        chk("data_held_3c", Rx_Data, 8'h3C);

        chk("final_flag_queue", flagQ.size(), 0);
        chk("final_abort_queue", abortQ.size(), 0);
        chk("final_rise_queue", riseQ.size(), 0);
        chk("final_byte_queue", byteQ.size(), 0);
        chk("final_eof_queue", eofQ.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hdlc_rx_framer.md
# hdlc_rx_framer

Serial receive front end of the HDLC controller. Takes the raw Rx bit stream (one bit per clock) and performs:
- flag and abort detection
- zero-bit removal
- byte assembly

It delivers the frame-status strobes consumed by the Rx buffer and status logic: Rx_FlagDetect, Rx_AbortDetect, Rx_ValidFrame, Rx_AbortSignal, Rx_EoF. It sits between the line input and the Rx frame buffer (Rx_WrBuff/overflow logic).

## Interface
- No parameters (flag 0111_1110, abort 0 followed by seven 1s, byte width 8 are fixed by HDLC).
- Clk  input  1  system clock; all state updates on rising edge.
- Rst  input  1  asynchronous, active-high reset.
- Rx  input  1  serial line bit, sampled every rising edge; idle level 1.
- Rx_Enable  input  1  when 0 no new frame is opened; a frame already open completes normally.
- Rx_FlagDetect  output  1  one-cycle pulse per detected flag.
- Rx_AbortDetect  output  1  one-cycle pulse per detected abort pattern (in or out of frame).
- Rx_ValidFrame  output  1  high while a frame is open.
- Rx_AbortSignal  output  1  one-cycle pulse: abort detected while Rx_ValidFrame=1.
- Rx_Data  output  8  last assembled byte; first-received bit in bit 0 (LSB first); held until next byte.
- Rx_NewByte  output  1  one-cycle strobe, Rx_Data valid this cycle.
- Rx_EoF  output  1  one-cycle pulse on frame close (closing flag or abort).
- Rx_FrameError  output  1  valid with Rx_EoF: 1 if frame closed by flag with data bit count not a multiple of 8, or closed by abort.

## Operation
- Reset: all outputs 0. Internal bit window resets to all 1s so no false flag/abort is seen after reset. Ones counter and bit counter reset to 0.
- Input path: Rx registered once, then shifted into an 8-bit window. Detection is combinational on the window, then registered.
- States:
  - IDLE. Flag with Rx_Enable=1 -> OPEN (Rx_ValidFrame rises the cycle after the Rx_FlagDetect pulse).
  - OPEN, no data bits yet. A further flag restarts OPEN (repeated opening flags): no Rx_EoF, Rx_ValidFrame stays 1.
  - OPEN, >=1 data bit:
    - Flag -> IDLE, with Rx_EoF pulse and Rx_FrameError = (bitcount mod 8 != 0).
    - Abort -> IDLE, with Rx_AbortSignal and Rx_EoF pulses and Rx_FrameError=1. Any partial byte is discarded.
  - The closing flag does not reopen a frame. A new flag is required.
- Data stream: exactly the bits strictly between the last bit of the opening flag and the first bit of the closing flag or abort pattern, in arrival order.
- Zero removal: a 0 immediately following five consecutive data 1s is dropped and not counted. Six 1s inside a frame can only be a flag or abort.
- Byte assembly: 8 accepted bits -> Rx_Data updated, Rx_NewByte pulses, bit count mod 8 returns to 0. Bytes are never emitted for flag or abort bits.
- Abort outside a frame: Rx_AbortDetect pulses only; Rx_AbortSignal and Rx_EoF stay 0.
- Continuous 1s (idle) after an abort produce no further Rx_AbortDetect. Only the 0->seven-1s transition detects.

## Timing
- Rx_FlagDetect: high at the 2nd rising edge after the edge sampling the flag's final 0.
- Rx_AbortDetect: high at the 2nd rising edge after the edge sampling the seventh 1.
- Rx_AbortSignal: 1 cycle after Rx_AbortDetect (when Rx_ValidFrame=1 at the Rx_AbortDetect edge).
- Rx_ValidFrame:
  - Rises 1 cycle after the opening Rx_FlagDetect.
  - Falls 1 cycle after the closing Rx_FlagDetect or Rx_AbortDetect.
  - Rx_EoF pulses in that same first low cycle, aligned with Rx_AbortSignal on abort.
- Rx_NewByte: exactly 10 cycles after the edge sampling the byte's last accepted data bit.
- A byte completed just before a closing flag is emitted before or in the same cycle as Rx_EoF, never after.
- Asynchronous reset mid-frame: outputs go to 0 immediately without waiting for a clock. The frame is lost and no Rx_EoF is produced.

## Test plan
- Reset, then Rx=1 for 30 cycles -> all outputs stay 0, no Rx_FlagDetect or Rx_AbortDetect.
- Flag, byte 0xA5 (LSB first), flag:
  - Rx_FlagDetect at +2 cycles after each flag's last 0.
  - One Rx_NewByte with Rx_Data=0xA5.
  - Rx_EoF=1 with Rx_FrameError=0.
  - Rx_ValidFrame timing as specified.
- Flag, 0xFF sent as 1,1,1,1,1,0,1,1,1, flag -> one Rx_NewByte with Rx_Data=0xFF; stuffed 0 not counted; Rx_FrameError=0.
- Flag, 0x12, 3 bits, then 0 + seven 1s:
  - Rx_NewByte once (0x12).
  - Rx_AbortDetect at +2 after the seventh 1, then Rx_AbortSignal and Rx_EoF next cycle, with Rx_FrameError=1.
  - Rx_ValidFrame falls.
- Flag, flag, 11 data bits, flag -> no Rx_EoF on the second flag; one Rx_NewByte; Rx_EoF with Rx_FrameError=1.
- Rst pulsed mid-byte in a frame -> outputs 0 at once, no Rx_EoF; a following flag/0x3C/flag frame is received correctly (Rx_Data=0x3C).
